score_keeper: RTL and testbench

Two-team scoreboard core that consumes the `count_up` / `count_down` pulses of two upstream pushbutton processors (team A, team B) and holds each team's score as two BCD digits. It tracks the leader and detects the end of a game at a configurable winning score. Its BCD digit outputs feed the 7-segment display multiplexer. Every output is registered; the block runs entirely in the 1 kHz domain of the pushbutton processors.

---
 rtl/score_keeper_if.sv | 39 +++
 rtl/score_keeper.sv | 182 ++++++++++++++++++
 tb/tb_score_keeper.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/score_keeper_if.sv
// Purpose: request/score bundle between the pushbutton processors, the
//          score_keeper core and the 7-segment display multiplexer.
// Signals:
//   clear_i                           - synchronous level clear / new game
//   a_up_i, a_down_i, b_up_i, b_down_i - per-team request pulses (multi-cycle)
//   a_tens_o, a_ones_o                - team A score, BCD
//   b_tens_o, b_ones_o                - team B score, BCD
//   lead_o                            - 00 tie, 01 A leads, 10 B leads
//   game_over_o                       - high while the game is over
//   winner_o                          - 00 none, 01 A, 10 B, 11 both
//   update_o                          - one-cycle strobe on any score change
// Modports: master = request source / display side, slave = score_keeper core.
interface score_keeper_if;
  logic       clear_i;
  logic       a_up_i;
  logic       a_down_i;
  logic       b_up_i;
  logic       b_down_i;
  logic [3:0] a_tens_o;
  logic [3:0] a_ones_o;
  logic [3:0] b_tens_o;
  logic [3:0] b_ones_o;
  logic [1:0] lead_o;
  logic       game_over_o;
  logic [1:0] winner_o;
  logic       update_o;

  modport master (
    output clear_i, a_up_i, a_down_i, b_up_i, b_down_i,
    input  a_tens_o, a_ones_o, b_tens_o, b_ones_o,
    input  lead_o, game_over_o, winner_o, update_o
  );

  modport slave (
    input  clear_i, a_up_i, a_down_i, b_up_i, b_down_i,
    output a_tens_o, a_ones_o, b_tens_o, b_ones_o,
    output lead_o, game_over_o, winner_o, update_o
  );
endinterface

// File: rtl/score_keeper.sv
// Purpose: two-team BCD scoreboard. Counts one event per rising edge of each
//          request input, keeps two-digit BCD scores, tracks the leader and
//          ends the game when a team reaches WIN_SCORE. All outputs registered.
// Ports:
//   clk_1khz - 1 kHz clock, rising edge
//   rst_ni   - asynchronous active-low reset
//   bus      - score_keeper_if.slave (requests in, scores/status out)
// Parameters:
//   WIN_SCORE - decimal score that ends the game (1..99)
module score_keeper #(
  parameter int unsigned WIN_SCORE = 21
) (
  input  logic          clk_1khz,
  input  logic          rst_ni,
  score_keeper_if.slave bus
);

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SCORE_W = 2 * DIGIT_W;
  localparam int unsigned REQ_W   = 4;
  localparam logic [SCORE_W-1:0] WIN_BCD =
    {DIGIT_W'(WIN_SCORE / 10), DIGIT_W'(WIN_SCORE % 10)};
  localparam logic [SCORE_W-1:0] MAX_BCD = 8'h99;

  localparam logic [1:0] LEAD_TIE = 2'b00;
  localparam logic [1:0] LEAD_A   = 2'b01;
  localparam logic [1:0] LEAD_B   = 2'b10;

  typedef enum logic {
    PLAY      = 1'b0,
    GAME_OVER = 1'b1
  } state_e;

  state_e             state_q;
  logic [SCORE_W-1:0] a_q;
  logic [SCORE_W-1:0] b_q;
  logic [1:0]         lead_q;
  logic [1:0]         winner_q;
  logic               game_over_q;
  logic               update_q;
  logic [REQ_W-1:0]   prev_q;

  logic [REQ_W-1:0]   req;
  logic [REQ_W-1:0]   ev;
  logic               a_inc;
  logic               a_dec;
  logic               b_inc;
  logic               b_dec;
  logic [SCORE_W-1:0] a_nxt;
  logic [SCORE_W-1:0] b_nxt;
  logic               a_win;
  logic               b_win;
  logic [1:0]         lead_nxt;
  logic               score_chg;

  // BCD +1, saturating at 99
  function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] s);
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
    tens = s[SCORE_W-1:DIGIT_W];
    ones = s[DIGIT_W-1:0];
    if (s == MAX_BCD) begin
      return s;
    end
    if (ones == 4'd9) begin
      return {tens + 4'd1, 4'd0};
    end
    return {tens, ones + 4'd1};
  endfunction

  // BCD -1, saturating at 00
  function automatic logic [SCORE_W-1:0] bcd_dec(input logic [SCORE_W-1:0] s);
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
    tens = s[SCORE_W-1:DIGIT_W];
    ones = s[DIGIT_W-1:0];
    if (s == '0) begin
      return s;
    end
    if (ones == 4'd0) begin
      return {tens - 4'd1, 4'd9};
    end
    return {tens, ones - 4'd1};
  endfunction

  // Rising-edge events; prev_q resets to 1 so a request held through reset is ignored
  assign req = {bus.a_up_i, bus.a_down_i, bus.b_up_i, bus.b_down_i};
  assign ev  = req & ~prev_q;

  // Simultaneous up and down on one team cancel out
  assign a_inc = ev[3] & ~ev[2];
  assign a_dec = ev[2] & ~ev[3];
  assign b_inc = ev[1] & ~ev[0];
  assign b_dec = ev[0] & ~ev[1];

  // Post-update scores, leader and win detection while playing
  always_comb begin
    a_nxt = a_q;
    b_nxt = b_q;
    if (a_inc) begin
      a_nxt = bcd_inc(a_q);
    end else if (a_dec) begin
      a_nxt = bcd_dec(a_q);
    end
    if (b_inc) begin
      b_nxt = bcd_inc(b_q);
    end else if (b_dec) begin
      b_nxt = bcd_dec(b_q);
    end

    a_win     = (a_nxt == WIN_BCD);
    b_win     = (b_nxt == WIN_BCD);
    score_chg = (a_nxt != a_q) || (b_nxt != b_q);

    // Packed BCD compares like decimal: tens nibble dominates
    if (a_nxt > b_nxt) begin
      lead_nxt = LEAD_A;
    end else if (b_nxt > a_nxt) begin
      lead_nxt = LEAD_B;
    end else begin
      lead_nxt = LEAD_TIE;
    end
  end

  // State, scores and all registered outputs
  always_ff @(posedge clk_1khz or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= PLAY;
      a_q         <= '0;
      b_q         <= '0;
      lead_q      <= LEAD_TIE;
      winner_q    <= 2'b00;
      game_over_q <= 1'b0;
      update_q    <= 1'b0;
      prev_q      <= '1;
    end else begin
      prev_q   <= req;
      update_q <= 1'b0;
      if (bus.clear_i) begin
        // Clear wins over any event in the same cycle
        state_q     <= PLAY;
        a_q         <= '0;
        b_q         <= '0;
        lead_q      <= LEAD_TIE;
        winner_q    <= 2'b00;
        game_over_q <= 1'b0;
        update_q    <= (a_q != '0) || (b_q != '0);
      end else begin
        case (state_q)
          PLAY: begin
            a_q      <= a_nxt;
            b_q      <= b_nxt;
            lead_q   <= lead_nxt;
            update_q <= score_chg;
            if (a_win || b_win) begin
              state_q     <= GAME_OVER;
              game_over_q <= 1'b1;
              winner_q    <= {b_win, a_win};
            end
          end
          GAME_OVER: begin
            // Scores frozen until clear
            state_q <= GAME_OVER;
          end
          default: begin
            state_q <= PLAY;
          end
        endcase
      end
    end
  end

  assign bus.a_tens_o    = a_q[SCORE_W-1:DIGIT_W];
  assign bus.a_ones_o    = a_q[DIGIT_W-1:0];
  assign bus.b_tens_o    = b_q[SCORE_W-1:DIGIT_W];
  assign bus.b_ones_o    = b_q[DIGIT_W-1:0];
  assign bus.lead_o      = lead_q;
  assign bus.game_over_o = game_over_q;
  assign bus.winner_o    = winner_q;
  assign bus.update_o    = update_q;

endmodule

// File: tb/tb_score_keeper.sv
// Purpose: directed self-checking bench for score_keeper (WIN_SCORE = 21).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_score_keeper;

  localparam logic [4:0] CLR  = 5'b10000;
  localparam logic [4:0] A_UP = 5'b01000;
  localparam logic [4:0] A_DN = 5'b00100;
  localparam logic [4:0] B_UP = 5'b00010;
  localparam logic [4:0] B_DN = 5'b00001;

  logic clk;
  logic rst_n;
  int   tests;
  int   failed;

  score_keeper_if bus ();

  score_keeper #(.WIN_SCORE(21)) dut (
    .clk_1khz (clk),
    .rst_ni   (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [1:0] lead_of(input int a, input int b);
    if (a > b) return 2'b01;
    if (b > a) return 2'b10;
    return 2'b00;
  endfunction

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input int xa, input int xb,
                     input logic xg, input logic [1:0] xw, input logic xu);
    cmp({tag, " a"},      {bus.a_tens_o, bus.a_ones_o}, bcd(xa));
    cmp({tag, " b"},      {bus.b_tens_o, bus.b_ones_o}, bcd(xb));
    cmp({tag, " lead"},   8'(bus.lead_o),      8'(lead_of(xa, xb)));
    cmp({tag, " over"},   8'(bus.game_over_o), 8'(xg));
    cmp({tag, " winner"}, 8'(bus.winner_o),    8'(xw));
    cmp({tag, " update"}, 8'(bus.update_o),    8'(xu));
  endtask

  task automatic drive(input logic [4:0] m);
    {bus.clear_i, bus.a_up_i, bus.a_down_i, bus.b_up_i, bus.b_down_i} = m;
  endtask

  // Hold mask m for w cycles, check the state after the first edge,
  // the update strobe dropping, and stability after release.
  task automatic pulse(input string tag, input logic [4:0] m, input int w,
                       input int xa, input int xb, input logic xg,
                       input logic [1:0] xw, input logic xu);
    drive(m);
    @(negedge clk);
    chk(tag, xa, xb, xg, xw, xu);
    for (int i = 1; i < w; i++) begin
      @(negedge clk);
      if (i == 1) cmp({tag, " strobe1"}, 8'(bus.update_o), 8'h00);
    end
    drive(5'b00000);
    @(negedge clk);
    chk({tag, " idle"}, xa, xb, xg, xw, 1'b0);
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst_n  = 1'b0;
    drive(5'b00000);
    repeat (3) @(negedge clk);
    chk("reset", 0, 0, 1'b0, 2'b00, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Long pulses count once
    pulse("a_up long1", A_UP, 11, 1, 0, 1'b0, 2'b00, 1'b1);
    pulse("a_up long2", A_UP, 11, 2, 0, 1'b0, 2'b00, 1'b1);

    // B to 09 with minimum-spaced pulses, then carry and borrow
    for (int i = 1; i <= 9; i++)
      pulse($sformatf("b_up %0d", i), B_UP, 1, 2, i, 1'b0, 2'b00, 1'b1);
    pulse("b carry", B_UP, 2, 2, 10, 1'b0, 2'b00, 1'b1);
    pulse("b borrow", B_DN, 2, 2, 9, 1'b0, 2'b00, 1'b1);

    // A down to 00, then decrement at 00 is ignored
    pulse("a_dn 1", A_DN, 2, 1, 9, 1'b0, 2'b00, 1'b1);
    pulse("a_dn 0", A_DN, 2, 0, 9, 1'b0, 2'b00, 1'b1);
    pulse("a_dn floor", A_DN, 3, 0, 9, 1'b0, 2'b00, 1'b0);

    // Up and down together cancel
    pulse("a up+dn", A_UP | A_DN, 3, 0, 9, 1'b0, 2'b00, 1'b0);

    // Reach 03 / 03, then both teams increment on one edge
    for (int i = 1; i <= 6; i++)
      pulse($sformatf("b_dn %0d", i), B_DN, 1, 0, 9 - i, 1'b0, 2'b00, 1'b1);
    for (int i = 1; i <= 3; i++)
      pulse($sformatf("a_up %0d", i), A_UP, 1, i, 3, 1'b0, 2'b00, 1'b1);
    pulse("ab up", A_UP | B_UP, 2, 4, 4, 1'b0, 2'b00, 1'b1);

    // Game end: A 20, B 15, then A wins
    for (int i = 1; i <= 11; i++)
      pulse($sformatf("b to15 %0d", i), B_UP, 1, 4, 4 + i, 1'b0, 2'b00, 1'b1);
    for (int i = 1; i <= 16; i++)
      pulse($sformatf("a to20 %0d", i), A_UP, 1, 4 + i, 15, 1'b0, 2'b00, 1'b1);
    pulse("a wins", A_UP, 2, 21, 15, 1'b1, 2'b01, 1'b1);
    pulse("frozen a_up", A_UP, 2, 21, 15, 1'b1, 2'b01, 1'b0);
    pulse("frozen b_dn", B_DN, 2, 21, 15, 1'b1, 2'b01, 1'b0);
    pulse("clear over", CLR, 1, 0, 0, 1'b0, 2'b00, 1'b1);

    // Both reach 21 on the same edge
    for (int i = 1; i <= 20; i++)
      pulse($sformatf("ab to20 %0d", i), A_UP | B_UP, 1, i, i, 1'b0, 2'b00, 1'b1);
    pulse("both win", A_UP | B_UP, 2, 21, 21, 1'b1, 2'b11, 1'b1);
    pulse("clear both", CLR, 1, 0, 0, 1'b0, 2'b00, 1'b1);
    pulse("clear at 00", CLR, 3, 0, 0, 1'b0, 2'b00, 1'b0);

    // Clear priority over a coincident rising edge, no late count
    for (int i = 1; i <= 5; i++)
      pulse($sformatf("a to5 %0d", i), A_UP, 1, i, 0, 1'b0, 2'b00, 1'b1);
    drive(CLR | A_UP);
    @(negedge clk);
    chk("clr+a_up", 0, 0, 1'b0, 2'b00, 1'b1);
    drive(A_UP);
    repeat (3) begin
      @(negedge clk);
      chk("a_up after clr", 0, 0, 1'b0, 2'b00, 1'b0);
    end
    drive(5'b00000);
    @(negedge clk);

    // Reset mid-game with a request held through release
    for (int i = 1; i <= 12; i++)
      pulse($sformatf("a to12 %0d", i), A_UP, 1, i, 0, 1'b0, 2'b00, 1'b1);
    #2;
    rst_n = 1'b0;
    drive(B_UP);
    #1;
    chk("async reset", 0, 0, 1'b0, 2'b00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("b held thru reset", 0, 0, 1'b0, 2'b00, 1'b0);
    end
    drive(5'b00000);
    @(negedge clk);
    pulse("b fresh", B_UP, 11, 0, 1, 1'b0, 2'b00, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
